uart_rx_byte: RTL and testbench

- UART receiver at the front of the serial data path: converts the asynchronous `rx` pin into 8-bit bytes.
- Presents each byte on `rx_data` with a `valid_flag` rising edge. The downstream row-buffer/sum controller edge-detects `valid_flag`, with reset/idle level high.
- Frame format is 8N1, LSB first. An even-parity bit is added when the optional feature is enabled.

---
 rtl/uart_rx_byte.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, byte out with valid_flag level.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_byte #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       valid_flag,
   output logic       frame_err
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
   localparam int CW = $clog2(BAUD_CNT_MAX);
   localparam logic [CW-1:0] SAMPLE_PT = CW'(BAUD_CNT_MAX / 2 - 1);
   localparam logic [CW-1:0] BIT_END   = CW'(BAUD_CNT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PAR,
`endif
      S_STOP
   } state_e;

   state_e state_q, state_d;

   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q;
   logic          valid_q;
   logic          ferr_q;

   logic start_edge;
   logic sample;
   logic bit_end;
   logic stop_ok;
   logic shift_en;
   logic clr_valid;
   logic accept;
   logic reject;

   assign start_edge = rx_s3_q & ~rx_s2_q;
   assign sample     = (baud_cnt_q == SAMPLE_PT);
   assign bit_end    = (baud_cnt_q == BIT_END);

`ifdef UART_RX_PARITY_EN
   logic par_ld;
   logic par_err_q, par_err_d;

   assign par_err_d = par_ld ? ^{shift_q, rx_s2_q} : par_err_q;
   assign stop_ok   = rx_s2_q & ~par_err_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) par_err_q <= 1'b0;
      else        par_err_q <= par_err_d;
   end
`else
   assign stop_ok = rx_s2_q;
`endif

   // two-flop synchroniser plus one stage for falling-edge detect
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_edge) state_d = S_START;
         S_START: begin
            if (sample && rx_s2_q) state_d = S_IDLE;
            else if (bit_end)      state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_d = S_PAR;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PAR:   if (bit_end) state_d = S_STOP;
`endif
         S_STOP:  if (sample) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      shift_en  = 1'b0;
      clr_valid = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ld    = 1'b0;
`endif
      unique case (state_q)
         S_START: clr_valid = sample & ~rx_s2_q;
         S_DATA:  shift_en  = sample;
`ifdef UART_RX_PARITY_EN
         S_PAR:   par_ld    = sample;
`endif
         S_STOP: begin
            accept = sample & stop_ok;
            reject = sample & ~stop_ok;
         end
         default: ;
      endcase
   end

   // bit timing restarts on every state change
   always_comb begin
      if (state_d != state_q || state_q == S_IDLE || bit_end)
         baud_cnt_d = '0;
      else
         baud_cnt_d = baud_cnt_q + CW'(1);
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (state_q != S_DATA) bit_cnt_d = 3'd0;
      else if (bit_end)      bit_cnt_d = bit_cnt_q + 3'd1;
   end

   assign shift_d = shift_en ? {rx_s2_q, shift_q[7:1]} : shift_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q <= 8'd0;
         valid_q   <= 1'b1;
         ferr_q    <= 1'b0;
      end else begin
         ferr_q <= reject;
         if (accept) begin
            rx_data_q <= shift_q;
            valid_q   <= 1'b1;
         end else if (clr_valid) begin
            valid_q   <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign valid_flag = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames into uart_rx_byte, scoreboard on outputs.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_byte;

   localparam int BCM  = 10;
   localparam int HALF = BCM / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int LAT = 3 + (NB - 1) * BCM + HALF;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx      = 1'b1;
   logic [7:0] rx_data;
   logic       valid_flag;
   logic       frame_err;

   uart_rx_byte #(
      .CLK_FREQ(50_000_000),
      .BAUD    (5_000_000)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .valid_flag(valid_flag),
      .frame_err (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         err;
      logic [7:0] d;
      int         t0;
   } exp_t;

   exp_t       q[$];
   logic [7:0] last_good = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [7:0] d, input bit stop, input bit par,
                       input bit push, input bit exp_err);
      logic [10:0] fr;
      exp_t        e;
      if (push) begin
         e.err = exp_err;
         e.d   = exp_err ? last_good : d;
         e.t0  = cyc;
         q.push_back(e);
         if (!exp_err) last_good = d;
      end
      fr[0]   = 1'b0;
      fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
      fr[9]  = par;
      fr[10] = stop;
`else
      fr[9]  = stop;
      fr[10] = 1'b1;
      if (par) fr[10] = 1'b1;
`endif
      for (int i = 0; i < NB; i++) begin
         rx = fr[i];
         repeat (BCM) @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic pop_chk(input bit is_err);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_%s: got event want none (cyc %0d)",
                  is_err ? "ferr" : "valid", cyc);
      end else begin
         e = q.pop_front();
         chk("kind", 32'(is_err), 32'(e.err));
         chk("rx_data", 32'(rx_data), 32'(e.d));
         if (is_err) chk("valid_on_err", 32'(valid_flag), 32'd0);
         total++;
         if (cyc - e.t0 < LAT || cyc - e.t0 > LAT + 2) begin
            bad++;
            $display("FAIL latency: got %0d want %0d..%0d",
                     cyc - e.t0, LAT, LAT + 2);
         end
      end
   endtask

   logic pv = 1'b1;
   logic pf = 1'b0;
   bit   err_next = 1'b0;

   always @(negedge sys_clk) begin
      if (!rst_n) begin
         err_next <= 1'b0;
      end else begin
         if (err_next) begin
            chk("ferr_one_cycle", 32'(frame_err), 32'd0);
            err_next <= 1'b0;
         end
         if (valid_flag && !pv) pop_chk(1'b0);
         if (frame_err && !pf) begin
            pop_chk(1'b1);
            err_next <= 1'b1;
         end
      end
      pv <= valid_flag;
      pf <= frame_err;
   end

   initial begin
      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset_vals", {valid_flag, frame_err, rx_data}, {1'b1, 1'b0, 8'h00});
      rst_n = 1'b1;

      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         chk("idle", {valid_flag, frame_err, rx_data}, {1'b1, 1'b0, 8'h00});
      end
      @(posedge sys_clk);
      #1;

      fork
         send(8'hA5, 1'b1, ^8'hA5, 1'b1, 1'b0);
         begin
            repeat (7) @(posedge sys_clk);
            @(negedge sys_clk);
            chk("valid_pre_fall", 32'(valid_flag), 32'd1);
            @(negedge sys_clk);
            chk("valid_fall", 32'(valid_flag), 32'd0);
         end
      join

      send(8'h00, 1'b1, ^8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, ^8'hFF, 1'b1, 1'b0);
      send(8'h3C, 1'b1, ^8'h3C, 1'b1, 1'b0);

      send(8'h55, 1'b0, ^8'h55, 1'b1, 1'b1);
      rx = 1'b1;
      repeat (20) @(posedge sys_clk);
      #1;
      send(8'h12, 1'b1, ^8'h12, 1'b1, 1'b0);
      repeat (20) @(posedge sys_clk);
      #1;

      rx = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         chk("glitch", {valid_flag, frame_err, rx_data}, {1'b1, 1'b0, 8'h12});
      end
      @(posedge sys_clk);
      #1;

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (20) @(posedge sys_clk);
      #1;
`endif

      fork
         send(8'h81, 1'b1, ^8'h81, 1'b0, 1'b0);
         begin
            repeat (55) @(posedge sys_clk);
            #1;
            rst_n = 1'b0;
            #1;
            chk("mid_reset", {valid_flag, frame_err, rx_data},
                {1'b1, 1'b0, 8'h00});
         end
      join
      rst_n = 1'b1;
      last_good = 8'h00;
      repeat (150) @(posedge sys_clk);
      #1;
      chk("post_reset", {valid_flag, frame_err, rx_data}, {1'b1, 1'b0, 8'h00});

      for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge sys_clk);
      chk("drain", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
